// File: rtl/alu_pkg.sv
// Shared opcode/funct constants, FSM state type and instruction decode for alu_issue.
// Word ops (OP-IMM-32 / OP-32) decode only when ALU_WORD_OPS_EN is defined.
package alu_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {StIdle, StIssue, StWb, StRej} state_e;

  typedef struct packed {
    logic        legal;
    logic        word;
    logic        imm;
    logic [63:0] imm_val;
  } dec_t;

  function automatic dec_t decode(logic [31:0] inst);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    d  = '0;
    f3 = inst[14:12];
    f7 = inst[31:25];
    case (inst[6:0])
      OPC_OP: begin
        d.legal = (f7 == F7_BASE && !f3[2]) || (f7 == F7_ALT && f3 == F3_ADD);
      end
      OPC_OP_IMM: begin
        d.imm     = 1'b1;
        d.imm_val = {{52{inst[31]}}, inst[31:20]};
        if (f3 == F3_SLL) begin
          d.legal   = (inst[31:26] == 6'd0);
          d.imm_val = {58'd0, inst[25:20]};
        end else begin
          d.legal = (f3 == F3_ADD) || (f3 == F3_SLT) || (f3 == F3_SLTU);
        end
      end
`ifdef ALU_WORD_OPS_EN
      OPC_OP_IMM_32: begin
        d.imm  = 1'b1;
        d.word = 1'b1;
        if (f3 == F3_SLL) begin
          d.legal   = (f7 == F7_BASE);
          d.imm_val = {59'd0, inst[24:20]};
        end else begin
          d.legal   = (f3 == F3_ADD);
          d.imm_val = {{52{inst[31]}}, inst[31:20]};
        end
      end
      OPC_OP_32: begin
        d.word  = 1'b1;
        d.legal = (f3 == F3_ADD && (f7 == F7_BASE || f7 == F7_ALT)) ||
                  (f3 == F3_SLL && f7 == F7_BASE);
      end
`endif
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x64 integer register file: two async read ports, one sync write port, async clear.
// x0 always reads zero and ignores writes.
module regfile (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [63:0] o_rdata1,
  output logic [63:0] o_rdata2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [63:0] i_wdata
);

  logic [63:0] r_mem [0:31];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (i_we && i_waddr != 5'd0) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? 64'd0 : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 64'd0 : r_mem[i_raddr2];

endmodule

// File: rtl/alu_issue.sv
// Single-issue front end for an external registered ALU: decode, operand read, issue, writeback.
// Define ALU_WORD_OPS_EN to accept OP-IMM-32 / OP-32 with 32-bit sign-extended results.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        inst_ready,
  output logic [63:0] alu_op1,
  output logic [63:0] alu_op2,
  output logic        alu_imm,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  input  logic [63:0] alu_res,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        illegal,
  output logic        busy
);

  state_e      r_state, w_next;
  logic [2:0]  r_cnt;
  logic [4:0]  r_rd;
  logic        r_word;
  logic [63:0] r_alu_op1, r_alu_op2;
  logic        r_alu_imm;
  logic [2:0]  r_alu_f3;
  logic [6:0]  r_alu_f7;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [63:0] r_wb_data;

  dec_t        w_dec;
  logic        w_accept;
  logic [63:0] w_rs1, w_rs2, w_res;

  assign w_dec    = decode(inst);
  assign w_accept = inst_valid & inst_ready;
  assign w_res    = r_word ? {{32{alu_res[31]}}, alu_res[31:0]} : alu_res;

  regfile u_regfile (
    .i_clk    (CLK),
    .i_rst_n  (RST_N),
    .i_raddr1 (inst[19:15]),
    .i_raddr2 (inst[24:20]),
    .o_rdata1 (w_rs1),
    .o_rdata2 (w_rs2),
    .i_we     (r_state == StWb),
    .i_waddr  (r_rd),
    .i_wdata  (w_res)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= StIdle;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_next = w_dec.legal ? StIssue : StRej;
      StIssue: if (r_cnt == 3'd1) w_next = StWb;
      StWb:    w_next = StIdle;
      StRej:   w_next = StIdle;
      default: w_next = StIdle;
    endcase
  end

  // RST_N gates ready so it drops the instant reset asserts.
  always_comb begin
    inst_ready = (r_state == StIdle) & RST_N;
    busy       = (r_state != StIdle);
    illegal    = (r_state == StRej);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt      <= '0;
      r_rd       <= '0;
      r_word     <= 1'b0;
      r_alu_op1  <= '0;
      r_alu_op2  <= '0;
      r_alu_imm  <= 1'b0;
      r_alu_f3   <= '0;
      r_alu_f7   <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      if (r_state == StIdle && w_accept && w_dec.legal) begin
        r_cnt     <= 3'(ALU_LAT);
        r_rd      <= inst[11:7];
        r_word    <= w_dec.word;
        r_alu_op1 <= w_rs1;
        // Word shifts use a 5-bit shift amount.
        if (w_dec.imm)                                r_alu_op2 <= w_dec.imm_val;
        else if (w_dec.word && inst[14:12] == F3_SLL) r_alu_op2 <= {59'd0, w_rs2[4:0]};
        else                                          r_alu_op2 <= w_rs2;
        r_alu_imm <= w_dec.imm;
        r_alu_f3  <= inst[14:12];
        r_alu_f7  <= inst[31:25];
      end
      if (r_state == StIssue) r_cnt <= r_cnt - 3'd1;
      if (r_state == StWb) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_data  <= w_res;
      end
    end
  end

  assign alu_op1    = r_alu_op1;
  assign alu_op2    = r_alu_op2;
  assign alu_imm    = r_alu_imm;
  assign alu_funct3 = r_alu_f3;
  assign alu_funct7 = r_alu_f7;
  assign wb_valid   = r_wb_valid;
  assign wb_rd      = r_wb_rd;
  assign wb_data    = r_wb_data;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: two instances (ALU_LAT=1 and ALU_LAT=3) with ALU models.
// Honours ALU_WORD_OPS_EN for the ADDIW expectation.
module tb_alu_issue;

  logic        CLK = 1'b0;
  logic        RST_N, rst3_n;
  logic        inst_valid, inst_valid3;
  logic [31:0] inst;

  logic        inst_ready, alu_imm, wb_valid, illegal, busy;
  logic [63:0] alu_op1, alu_op2, alu_res, wb_data;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [4:0]  wb_rd;

  logic        inst_ready3, alu_imm3, wb_valid3, illegal3, busy3;
  logic [63:0] alu_op13, alu_op23, alu_res3, wb_data3;
  logic [2:0]  alu_funct33;
  logic [6:0]  alu_funct73;
  logic [4:0]  wb_rd3;

  always #5 CLK = ~CLK;

  alu_issue #(.ALU_LAT(1)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_imm(alu_imm), .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7), .alu_res(alu_res), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .illegal(illegal), .busy(busy)
  );

  alu_issue #(.ALU_LAT(3)) u_dut3 (
    .CLK(CLK), .RST_N(rst3_n), .inst_valid(inst_valid3), .inst(inst), .inst_ready(inst_ready3),
    .alu_op1(alu_op13), .alu_op2(alu_op23), .alu_imm(alu_imm3), .alu_funct3(alu_funct33),
    .alu_funct7(alu_funct73), .alu_res(alu_res3), .wb_valid(wb_valid3), .wb_rd(wb_rd3),
    .wb_data(wb_data3), .illegal(illegal3), .busy(busy3)
  );

  function automatic logic [63:0] alu_f(logic [63:0] a, logic [63:0] b, logic [2:0] f3,
                                        logic [6:0] f7, logic imm);
    case (f3)
      3'b000:  return (!imm && f7[5]) ? a - b : a + b;
      3'b001:  return a << b[5:0];
      3'b010:  return {63'd0, $signed(a) < $signed(b)};
      3'b011:  return {63'd0, a < b};
      default: return a ^ b;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    alu_res  <= alu_f(alu_op1, alu_op2, alu_funct3, alu_funct7, alu_imm);
    alu_res3 <= alu_f(alu_op13, alu_op23, alu_funct33, alu_funct73, alu_imm3);
  end

  typedef struct {
    logic        ill;
    logic [4:0]  rd;
    logic [63:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_pass = 0;
  int   n_total = 0;

  int          g_lat;
  bit          g_wb, g_ill;
  logic [63:0] g_op2, g_data;
  logic        g_imm;
  logic [6:0]  g_f7;
  logic [4:0]  g_rd;

  // Offer one instruction to the selected instance; returns just after the accept edge.
  task automatic send(input bit sel, input logic [31:0] w);
    int k = 0;
    while (!(sel ? inst_ready3 : inst_ready) && k < 20) begin
      @(posedge CLK); #1; k++;
    end
    if (k == 20) begin
      n_total++;
      $display("FAIL send_ready: inst_ready stayed 0, required 1");
    end
    inst = w;
    if (sel) inst_valid3 = 1'b1; else inst_valid = 1'b1;
    @(posedge CLK); #1;
    inst_valid  = 1'b0;
    inst_valid3 = 1'b0;
  endtask

  // Returns at the negedge where wb_valid or illegal is first seen (bounded).
  task automatic run(input bit sel, input logic [31:0] w);
    send(sel, w);
    g_lat = 0; g_wb = 0; g_ill = 0;
    @(negedge CLK);
    g_op2 = sel ? alu_op23 : alu_op2;
    g_imm = sel ? alu_imm3 : alu_imm;
    g_f7  = sel ? alu_funct73 : alu_funct7;
    for (int i = 0; i < 20; i++) begin
      if (sel ? wb_valid3 : wb_valid) begin g_wb = 1; break; end
      if (sel ? illegal3 : illegal) begin g_ill = 1; break; end
      g_lat++;
      @(negedge CLK);
    end
    g_rd   = sel ? wb_rd3 : wb_rd;
    g_data = sel ? wb_data3 : wb_data;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; rst3_n = 1'b0; inst_valid = 1'b0; inst_valid3 = 1'b0; inst = '0;
    repeat (3) @(negedge CLK);
    n_total++;
    if ({inst_ready, busy, wb_valid, illegal, alu_imm, alu_funct3, alu_funct7, wb_rd} !== '0 ||
        (alu_op1 | alu_op2 | wb_data) !== 64'd0)
      $display("FAIL reset_outputs: ready=%b busy=%b wbv=%b ill=%b op1=%h op2=%h wbd=%h, required all 0",
               inst_ready, busy, wb_valid, illegal, alu_op1, alu_op2, wb_data);
    else n_pass++;
    n_total++;
    if ({inst_ready3, busy3, wb_valid3, illegal3} !== 4'b0000)
      $display("FAIL reset_outputs3: got %b required 0000", {inst_ready3, busy3, wb_valid3, illegal3});
    else n_pass++;
    RST_N = 1'b1; rst3_n = 1'b1;
    #1;
    n_total++;
    if ({inst_ready, busy} !== 2'b10)
      $display("FAIL reset_release: ready,busy=%b required 10", {inst_ready, busy});
    else n_pass++;
    @(posedge CLK); #1;
  endtask

  task automatic test_addi;
    sb.push_back('{1'b0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFB, 2});
    run(0, 32'hFFB00093);
    e = sb.pop_front();
    n_total++;
    if (g_imm !== 1'b1 || g_op2 !== 64'hFFFF_FFFF_FFFF_FFFB)
      $display("FAIL addi_issue: imm=%b op2=%h required imm=1 op2=fffffffffffffffb", g_imm, g_op2);
    else n_pass++;
    n_total++;
    if (g_wb !== 1'b1 || g_lat != e.lat)
      $display("FAIL addi_latency: wb=%b lat=%0d required wb=1 lat=%0d", g_wb, g_lat, e.lat);
    else n_pass++;
    n_total++;
    if (g_rd !== e.rd || g_data !== e.data)
      $display("FAIL addi_wb: rd=%0d data=%h required rd=%0d data=%h", g_rd, g_data, e.rd, e.data);
    else n_pass++;
  endtask

  task automatic test_sub_back_to_back;
    run(0, 32'h00500093);  // addi x1,x0,5
    run(0, 32'h00700113);  // addi x2,x0,7
    sb.push_back('{1'b0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE, 2});
    run(0, 32'h402081B3);  // sub x3,x1,x2
    e = sb.pop_front();
    n_total++;
    if (g_f7 !== 7'b0100000 || g_imm !== 1'b0)
      $display("FAIL sub_issue: funct7=%b imm=%b required 0100000 0", g_f7, g_imm);
    else n_pass++;
    n_total++;
    if (g_wb !== 1'b1 || g_rd !== e.rd || g_data !== e.data)
      $display("FAIL sub_wb: wb=%b rd=%0d data=%h required 1 %0d %h", g_wb, g_rd, g_data, e.rd, e.data);
    else n_pass++;
    n_total++;
    if (inst_ready !== 1'b1)
      $display("FAIL sub_ready_at_wb: inst_ready=%b required 1", inst_ready);
    else n_pass++;
    sb.push_back('{1'b0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 2});
    run(0, 32'h00018213);  // addi x4,x3,0 offered in the wb_valid cycle
    e = sb.pop_front();
    n_total++;
    if (g_rd !== e.rd || g_data !== e.data || g_lat != e.lat)
      $display("FAIL raw_follow: rd=%0d data=%h lat=%0d required %0d %h %0d",
               g_rd, g_data, g_lat, e.rd, e.data, e.lat);
    else n_pass++;
  endtask

  task automatic test_illegal_x0;
    sb.push_back('{1'b1, 5'd0, 64'd0, 0});
    run(0, 32'h0020C1B3);  // xor x3,x1,x2
    e = sb.pop_front();
    n_total++;
    if (g_ill !== e.ill || g_wb !== 1'b0 || g_lat != e.lat)
      $display("FAIL xor_reject: ill=%b wb=%b lat=%0d required 1 0 %0d", g_ill, g_wb, g_lat, e.lat);
    else n_pass++;
    @(negedge CLK);
    n_total++;
    if (illegal !== 1'b0 || wb_valid !== 1'b0)
      $display("FAIL xor_pulse: ill=%b wbv=%b required 0 0", illegal, wb_valid);
    else n_pass++;
    sb.push_back('{1'b0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 2});
    run(0, 32'h00018213);  // addi x4,x3,0
    e = sb.pop_front();
    n_total++;
    if (g_data !== e.data)
      $display("FAIL xor_x3_kept: data=%h required %h", g_data, e.data);
    else n_pass++;
    sb.push_back('{1'b0, 5'd0, 64'd1, 2});
    run(0, 32'h00100013);  // addi x0,x0,1
    e = sb.pop_front();
    n_total++;
    if (g_wb !== 1'b1 || g_rd !== e.rd)
      $display("FAIL x0_wb: wb=%b rd=%0d required 1 %0d", g_wb, g_rd, e.rd);
    else n_pass++;
    sb.push_back('{1'b0, 5'd6, 64'd0, 2});
    run(0, 32'h00000333);  // add x6,x0,x0
    e = sb.pop_front();
    n_total++;
    if (g_rd !== e.rd || g_data !== e.data)
      $display("FAIL x0_reads_zero: rd=%0d data=%h required %0d %h", g_rd, g_data, e.rd, e.data);
    else n_pass++;
  endtask

  task automatic test_word;
    run(0, 32'h00100093);  // addi x1,x0,1
    run(0, 32'h01F09093);  // slli x1,x1,31
    sb.push_back('{1'b0, 5'd1, 64'h0000_0000_7FFF_FFFF, 2});
    run(0, 32'hFFF08093);  // addi x1,x1,-1
    e = sb.pop_front();
    n_total++;
    if (g_data !== e.data)
      $display("FAIL word_setup: x1=%h required %h", g_data, e.data);
    else n_pass++;
`ifdef ALU_WORD_OPS_EN
    sb.push_back('{1'b0, 5'd5, 64'hFFFF_FFFF_8000_0000, 2});
`else
    sb.push_back('{1'b1, 5'd0, 64'd0, 0});
`endif
    run(0, 32'h0010829B);  // addiw x5,x1,1
    e = sb.pop_front();
    n_total++;
    if (g_ill !== e.ill || g_wb !== !e.ill)
      $display("FAIL addiw_kind: ill=%b wb=%b required ill=%b", g_ill, g_wb, e.ill);
    else n_pass++;
    if (!e.ill) begin
      n_total++;
      if (g_rd !== e.rd || g_data !== e.data)
        $display("FAIL addiw_wb: rd=%0d data=%h required %0d %h", g_rd, g_data, e.rd, e.data);
      else n_pass++;
    end
  endtask

  task automatic test_abort;
    int seen = 0;
    sb.push_back('{1'b0, 5'd7, 64'd9, 4});
    run(1, 32'h00900393);  // addi x7,x0,9 on ALU_LAT=3
    e = sb.pop_front();
    n_total++;
    if (g_wb !== 1'b1 || g_lat != e.lat || g_data !== e.data)
      $display("FAIL lat3_wb: wb=%b lat=%0d data=%h required 1 %0d %h", g_wb, g_lat, g_data, e.lat, e.data);
    else n_pass++;
    send(1, 32'h00138393);  // addi x7,x7,1, aborted in ISSUE
    @(negedge CLK);
    rst3_n = 1'b0;
    #1;
    n_total++;
    if ({inst_ready3, busy3, wb_valid3, illegal3} !== 4'b0000)
      $display("FAIL abort_outputs: got %b required 0000", {inst_ready3, busy3, wb_valid3, illegal3});
    else n_pass++;
    repeat (2) begin @(negedge CLK); if (wb_valid3) seen++; end
    rst3_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (wb_valid3) seen++;
    end
    n_total++;
    if (seen != 0 || {inst_ready3, busy3} !== 2'b10)
      $display("FAIL abort_idle: wb_valid seen %0d ready,busy=%b required 0 and 10", seen, {inst_ready3, busy3});
    else n_pass++;
    sb.push_back('{1'b0, 5'd8, 64'd0, 4});
    run(1, 32'h00038413);  // addi x8,x7,0
    e = sb.pop_front();
    n_total++;
    if (g_wb !== 1'b1 || g_rd !== e.rd || g_data !== e.data)
      $display("FAIL abort_rd_zero: wb=%b rd=%0d data=%h required 1 %0d %h", g_wb, g_rd, g_data, e.rd, e.data);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sub_back_to_back();
    test_illegal_x0();
    test_word();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter: ALU_LAT, 1, cycles alu_op*/alu_funct* are held stable before alu_res is sampled (1..7).
REQ-002 SHALL have port: CLK  in  1  sole clock, rising edge.
REQ-003 SHALL have port: RST_N  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: inst_valid  in  1  instruction offered.
REQ-005 SHALL have port: inst  in  32  RISC-V instruction word.
REQ-006 SHALL have port: inst_ready  out  1  instruction accepted when inst_valid & inst_ready at a CLK edge.
REQ-007 SHALL have ports to the ALU: alu_op1 out 64, alu_op2 out 64, alu_imm out 1, alu_funct3 out 3, alu_funct7 out 7, alu_res in 64 (registered by ALU on CLK).
REQ-008 SHALL have ports: wb_valid out 1, wb_rd out 5, wb_data out 64 (retire record), illegal out 1 (reject pulse), busy out 1.

Function
REQ-009 SHALL implement FSM IDLE -> ISSUE -> WB -> IDLE; illegal path IDLE -> REJ -> IDLE.
REQ-010 IDLE: inst_ready=1, busy=0; on accept, decode inst, read rs1/rs2 from internal register file, latch operands.
REQ-011 ISSUE: drive operands/funct for exactly ALU_LAT cycles (down-counter), inst_ready=0, busy=1.
REQ-012 WB: capture alu_res, wb_valid=1 for one cycle, write rd at end of WB; latency accept edge to wb_valid high = ALU_LAT+1 cycles.
REQ-013 OP (0110011): alu_op1=rs1, alu_op2=rs2, alu_imm=0, funct7=inst[31:25]; legal only for funct3 000..011, funct7 0000000, or funct7 0100000 with funct3 000.
REQ-014 OP-IMM (0010011): alu_op2=sign-extended inst[31:20], alu_imm=1; funct3 001 legal only with inst[31:26]=0, op2=zero-extended shamt inst[25:20]; funct3 000/010/011 legal.
REQ-015 Any other opcode/funct3 (100..111) SHALL be illegal: illegal=1 one cycle in REJ, no ALU issue, no wb_valid, register file unchanged.
REQ-016 x0 SHALL read 0; writes to rd=0 SHALL be dropped while wb_valid still pulses with wb_rd=0.
REQ-017 Non-ISSUE cycles SHALL hold alu_* outputs at last driven values; wb_data/wb_rd hold until next WB.
REQ-018 Next instruction SHALL be accepted no earlier than the cycle after WB/REJ, so read-after-write needs no bypass.

Reset
REQ-019 RST_N low SHALL immediately force IDLE, all outputs 0 except inst_ready (0 while RST_N low, 1 in first cycle after release), clear x1..x31 to 0.
REQ-020 Reset during ISSUE/WB SHALL abort: no wb_valid, no register write.

Configuration
REQ-021 Macro ALU_WORD_OPS_EN defined: OP-IMM-32 (0011011, funct3 000/001 with inst[25]=0) and OP-32 (0111011, funct3 000 add/sub, 001 sll) legal; op2 shift amount masked to 5 bits; wb_data = sign-extend alu_res[31:0].
REQ-022 Macro undefined: opcodes 0011011/0111011 illegal per REQ-015.

Structure
REQ-023 SHALL share package alu_pkg: opcode constants, funct3/funct7 codes, FSM state enum.
REQ-024 SHALL instantiate one sub-module regfile: 32x64, 2 async read ports, 1 sync write port, async active-low clear.

Verification
REQ-025 Reset: RST_N low 3 cycles -> all outputs 0; after release inst_ready=1, busy=0.
REQ-026 ADDI x1,x0,-5 (0xFFB00093) -> alu_imm=1, alu_op2=0xFFFFFFFFFFFFFFFB; wb_valid 2 cycles after accept (ALU_LAT=1), wb_rd=1, wb_data=0xFFFFFFFFFFFFFFFB.
REQ-027 x1=5, x2=7, SUB x3,x1,x2 (0x402081B3) -> alu_funct7=0100000, wb_data=0xFFFFFFFFFFFFFFFE; immediate follow-up reading x3 sees new value.
REQ-028 XOR x3,x1,x2 (0x0020C1B3) -> illegal one cycle, no wb_valid, x3 unchanged; ADDI x0,x0,1 (0x00100013) -> wb_rd=0, x0 still reads 0.
REQ-029 x1=0x7FFFFFFF, ADDIW x5,x1,1 (0x0010829B) -> with ALU_WORD_OPS_EN wb_data=0xFFFFFFFF80000000; without, illegal pulse.
REQ-030 RST_N low during ISSUE with ALU_LAT=3 -> no wb_valid, target rd reads 0, FSM IDLE.
